// File: rtl/iterative_alu_if.sv
// Request/response bundle between the EX-stage issue logic and the iterative ALU.
// The ALU side uses the slave modport.
interface iterative_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_in_1;
    logic [XLEN-1:0] alu_in_2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    modport master (
        output in_valid, alu_op, alu_in_1, alu_in_2, out_ready,
        input  in_ready, out_valid, alu_result, alu_zero
    );

    modport slave (
        input  in_valid, alu_op, alu_in_1, alu_in_2, out_ready,
        output in_ready, out_valid, alu_result, alu_zero
    );
endinterface

// File: rtl/iterative_alu.sv
// Handshaked EX-stage ALU: single-cycle logic/shift/compare ops plus radix-2
// iterative MUL/MULHU/DIVU/REMU that run XLEN steps behind valid/ready.
module iterative_alu #(
    parameter int XLEN      = 32,
    parameter bit EN_MULDIV = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    iterative_alu_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic [SHW-1:0]    counter;
    logic [1:0]        op_sel;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;

    logic              accept;
    logic              is_iter;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   comb_result;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   iter_result;

    assign is_iter = EN_MULDIV && (bus.alu_op >= 4'd10) && (bus.alu_op <= 4'd13);
    assign shamt   = bus.alu_in_2[SHW-1:0];

    always_comb begin
        comb_result = '0;
        case (bus.alu_op)
            4'd0: comb_result = bus.alu_in_1 + bus.alu_in_2;
            4'd1: comb_result = bus.alu_in_1 - bus.alu_in_2;
            4'd2: comb_result = bus.alu_in_1 & bus.alu_in_2;
            4'd3: comb_result = bus.alu_in_1 | bus.alu_in_2;
            4'd4: comb_result = bus.alu_in_1 ^ bus.alu_in_2;
            4'd5: comb_result = bus.alu_in_1 << shamt;
            4'd6: comb_result = bus.alu_in_1 >> shamt;
            4'd7: comb_result = $unsigned($signed(bus.alu_in_1) >>> shamt);
            4'd8: comb_result = {{(XLEN-1){1'b0}}, ($signed(bus.alu_in_1) < $signed(bus.alu_in_2))};
            4'd9: comb_result = {{(XLEN-1){1'b0}}, (bus.alu_in_1 < bus.alu_in_2)};
            default: comb_result = '0;
        endcase
    end

    // Multiply keeps the multiplier in acc's low half and shifts the product in
    // from the top; divide keeps the dividend/quotient in acc's low half.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        rem_shift = {rem, acc[XLEN-1]};
        diff      = rem_shift - {1'b0, opb};
        if (op_sel[1]) begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
            rem_step = rem;
        end else begin
            acc_step = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~diff[XLEN]};
            rem_step = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
        end
        case (op_sel)
            2'b10:   iter_result = acc_step[XLEN-1:0];
            2'b11:   iter_result = acc_step[2*XLEN-1:XLEN];
            2'b00:   iter_result = acc_step[XLEN-1:0];
            default: iter_result = rem_step;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state_next = is_iter ? BUSY : DONE;
                    end else if (state == DONE && bus.out_ready) begin
                        state_next = IDLE;
                    end
                end
                BUSY: begin
                    if (counter == '0) begin
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready   = !reset && !flush &&
                         (state == IDLE || (state == DONE && bus.out_ready));
        bus.out_valid  = (state == DONE);
        bus.alu_result = result_q;
        bus.alu_zero   = zero_q;
        accept         = bus.in_valid && bus.in_ready;
    end

    // A flush mid-BUSY freezes the datapath; alu_result keeps its old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter  <= '0;
            op_sel   <= '0;
            acc      <= '0;
            rem      <= '0;
            opb      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            if (is_iter) begin
                counter <= SHW'(XLEN - 1);
                op_sel  <= bus.alu_op[1:0];
                rem     <= '0;
                if (bus.alu_op[1]) begin
                    acc <= {{XLEN{1'b0}}, bus.alu_in_2};
                    opb <= bus.alu_in_1;
                end else begin
                    acc <= {{XLEN{1'b0}}, bus.alu_in_1};
                    opb <= bus.alu_in_2;
                end
            end else begin
                result_q <= comb_result;
                zero_q   <= (comb_result == '0);
            end
        end else if (state == BUSY && !flush) begin
            acc     <= acc_step;
            rem     <= rem_step;
            counter <= counter - SHW'(1);
            if (counter == '0) begin
                result_q <= iter_result;
                zero_q   <= (iter_result == '0);
            end
        end
    end
endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu: a full build plus an
// EN_MULDIV=0 build sharing clock and reset.
module tb_iterative_alu;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic flush2;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    iterative_alu_if #(.XLEN(32)) bus ();
    iterative_alu_if #(.XLEN(32)) bus2 ();

    iterative_alu #(.XLEN(32), .EN_MULDIV(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    iterative_alu #(.XLEN(32), .EN_MULDIV(1'b0)) dut_nomd (
        .clk   (clk),
        .reset (reset),
        .flush (flush2),
        .bus   (bus2)
    );

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_in_ready_low: got %0b expected 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid_low: got %0b expected 0", bus.out_valid);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.alu_result !== 32'h0 || bus.alu_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_result: got %h/%0b expected 00000000/0", bus.alu_result, bus.alu_zero);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus2.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL post_reset_in_ready: got %0b/%0b expected 1/1", bus.in_ready, bus2.in_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ops   [0:3];
        logic [31:0] as    [0:3];
        logic [31:0] bs    [0:3];
        logic [31:0] exp_r [0:3];
        logic        exp_z [0:3];
        ops   = '{4'd0, 4'd8, 4'd9, 4'd7};
        as    = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        bs    = '{32'hFFFF_FFF9, 32'd1, 32'd1, 32'h24};
        exp_r = '{32'h0, 32'h1, 32'h0, 32'hF800_0000};
        exp_z = '{1'b1, 1'b0, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.alu_result !== exp_r[i-1] || bus.alu_zero !== exp_z[i-1]) begin
                    failures++;
                    $display("[TB] FAIL b2b_result_%0d: got v=%0b r=%h z=%0b expected v=1 r=%h z=%0b",
                             i-1, bus.out_valid, bus.alu_result, bus.alu_zero, exp_r[i-1], exp_z[i-1]);
                end
            end
            if (i < 4) begin
                bus.alu_op   = ops[i];
                bus.alu_in_1 = as[i];
                bus.alu_in_2 = bs[i];
                bus.in_valid = 1'b1;
                #1;
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_in_ready_%0d: got %0b expected 1", i, bus.in_ready);
                end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_drain: got out_valid=%0b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_muldiv;
        logic [3:0]  ops   [0:7];
        logic [31:0] as    [0:7];
        logic [31:0] bs    [0:7];
        logic [31:0] exp_r [0:7];
        int          n;
        logic        rdy_bad;
        ops   = '{4'd10, 4'd11, 4'd10, 4'd12, 4'd13, 4'd12, 4'd13, 4'd13};
        as    = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd6, 32'd100, 32'd100, 32'd5, 32'd5, 32'd21};
        bs    = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd7, 32'd0, 32'd0, 32'd7};
        exp_r = '{32'h1, 32'hFFFF_FFFE, 32'd42, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'd0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.alu_op   = ops[i];
            bus.alu_in_1 = as[i];
            bus.alu_in_2 = bs[i];
            bus.in_valid = 1'b1;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL muldiv_accept_%0d: got in_ready=%0b expected 1", i, bus.in_ready);
            end
            n = 0;
            rdy_bad = 1'b0;
            do begin
                @(negedge clk);
                n++;
                if (bus.out_valid !== 1'b1) begin
                    if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
                    bus.alu_op   = 4'($urandom_range(0, 15));
                    bus.alu_in_1 = $urandom;
                    bus.alu_in_2 = $urandom;
                    bus.in_valid = 1'($urandom_range(0, 1));
                end
            end while (bus.out_valid !== 1'b1 && n < 40);
            bus.in_valid = 1'b0;
            checks++;
            if (n != 33) begin
                failures++;
                $display("[TB] FAIL muldiv_latency_%0d: got %0d cycles expected 33", i, n);
            end
            checks++;
            if (rdy_bad !== 1'b0) begin
                failures++;
                $display("[TB] FAIL muldiv_busy_in_ready_%0d: got in_ready high during BUSY expected low", i);
            end
            checks++;
            if (bus.alu_result !== exp_r[i] || bus.alu_zero !== (exp_r[i] == 32'h0)) begin
                failures++;
                $display("[TB] FAIL muldiv_result_%0d: got %h z=%0b expected %h z=%0b",
                         i, bus.alu_result, bus.alu_zero, exp_r[i], (exp_r[i] == 32'h0));
            end
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        bus.alu_op    = 4'd0;
        bus.alu_in_1  = 32'd1;
        bus.alu_in_2  = 32'd2;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.alu_op   = 4'd1;
        bus.alu_in_1 = 32'd10;
        bus.alu_in_2 = 32'd4;
        for (int j = 0; j < 5; j++) begin
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd3 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL backpressure_hold_%0d: got v=%0b r=%h rdy=%0b expected v=1 r=00000003 rdy=0",
                         j, bus.out_valid, bus.alu_result, bus.in_ready);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL backpressure_release_ready: got %0b expected 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd6) begin
            failures++;
            $display("[TB] FAIL backpressure_next_op: got v=%0b r=%h expected v=1 r=00000006", bus.out_valid, bus.alu_result);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL backpressure_drain: got out_valid=%0b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_flush;
        logic seen;
        @(negedge clk);
        bus.alu_op    = 4'd12;
        bus.alu_in_1  = 32'd1000;
        bus.alu_in_2  = 32'd3;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        flush        = 1'b1;
        bus.alu_op   = 4'd0;
        bus.alu_in_1 = 32'd1;
        bus.alu_in_2 = 32'd1;
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_in_ready: got %0b expected 0", bus.in_ready);
        end
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.alu_result !== 32'd6 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_to_idle: got v=%0b r=%h rdy=%0b expected v=0 r=00000006 rdy=1",
                     bus.out_valid, bus.alu_result, bus.in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_no_pulse: got out_valid pulse expected none");
        end
        bus.alu_op   = 4'd0;
        bus.alu_in_1 = 32'd2;
        bus.alu_in_2 = 32'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd5 || bus.alu_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_then_add: got v=%0b r=%h z=%0b expected v=1 r=00000005 z=0",
                     bus.out_valid, bus.alu_result, bus.alu_zero);
        end
    endtask

    task automatic test_reset_mid_mul;
        logic seen;
        @(negedge clk);
        bus.alu_op    = 4'd10;
        bus.alu_in_1  = 32'd3;
        bus.alu_in_2  = 32'd5;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_in_ready: got %0b expected 0", bus.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.alu_result !== 32'h0 || bus.alu_zero !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid_mul: got v=%0b r=%h z=%0b rdy=%0b expected v=0 r=00000000 z=0 rdy=1",
                     bus.out_valid, bus.alu_result, bus.alu_zero, bus.in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_no_pulse: got out_valid pulse expected none");
        end
        bus.alu_op   = 4'd0;
        bus.alu_in_1 = 32'd4;
        bus.alu_in_2 = 32'd4;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'd8) begin
            failures++;
            $display("[TB] FAIL reset_then_add: got v=%0b r=%h expected v=1 r=00000008", bus.out_valid, bus.alu_result);
        end
    endtask

    task automatic test_unsupported;
        @(negedge clk);
        bus.alu_op   = 4'd14;
        bus.alu_in_1 = 32'd5;
        bus.alu_in_2 = 32'd6;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.alu_result !== 32'h0 || bus.alu_zero !== 1'b1) begin
            failures++;
            $display("[TB] FAIL op14_result: got v=%0b r=%h z=%0b expected v=1 r=00000000 z=1",
                     bus.out_valid, bus.alu_result, bus.alu_zero);
        end
        bus2.out_ready = 1'b1;
        bus2.alu_op    = 4'd0;
        bus2.alu_in_1  = 32'd3;
        bus2.alu_in_2  = 32'd4;
        bus2.in_valid  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.alu_result !== 32'd7) begin
            failures++;
            $display("[TB] FAIL nomd_add: got v=%0b r=%h expected v=1 r=00000007", bus2.out_valid, bus2.alu_result);
        end
        bus2.alu_op = 4'd10;
        #1;
        checks++;
        if (bus2.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL nomd_in_ready: got %0b expected 1", bus2.in_ready);
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.alu_result !== 32'h0 || bus2.alu_zero !== 1'b1) begin
            failures++;
            $display("[TB] FAIL nomd_mul: got v=%0b r=%h z=%0b expected v=1 r=00000000 z=1",
                     bus2.out_valid, bus2.alu_result, bus2.alu_zero);
        end
        @(negedge clk);
        checks++;
        if (bus2.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nomd_drain: got out_valid=%0b expected 0", bus2.out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        flush2         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.alu_op     = 4'd0;
        bus.alu_in_1   = 32'd0;
        bus.alu_in_2   = 32'd0;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b0;
        bus2.alu_op    = 4'd0;
        bus2.alu_in_1  = 32'd0;
        bus2.alu_in_2  = 32'd0;

        test_reset();
        test_back_to_back();
        test_muldiv();
        test_backpressure();
        test_flush();
        test_reset_mid_mul();
        test_unsupported();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
